onehot_prio_select: RTL and testbench
=====================================

Name: onehot_prio_select

Overview:
- Strict-priority one-hot arbiter fused with a one-hot AND-OR data multiplexer.
- Converts an N-bit request vector into a one-hot grant, lowest index highest priority.
- Routes the granted port's data word to a single output.
- Also exposes a standalone one-hot mux path with an externally supplied select, as used by the bus arbiters for address/data-phase signal steering.

Parameters:
- N_PORTS, default 2: number of requesters / mux inputs; legal range ≥1.
- W_DATA, default 32: width of each data word carried by the mux.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- canchange  input  1  0 = pure strict priority; 1 = sticky grant (hold the previous winner while it still requests)
- req  input  N_PORTS  request vector, bit i = port i
- gnt  output  N_PORTS  one-hot (or zero) grant
- gnt_data_in  input  N_PORTS*W_DATA  packed data, port i at [i*W_DATA +: W_DATA]
- gnt_data_out  output  W_DATA  gnt_data_in word selected by gnt
- mux_sel  input  N_PORTS  external select for the standalone mux
- mux_in  input  N_PORTS*W_DATA  packed data for the standalone mux
- mux_out  output  W_DATA  mux_in selected by mux_sel

Behaviour:
- Priority function: prio(req) has bit i set iff req[i]=1 and req[j]=0 for all j<i; all-zero if req=0.
- Mux function: out = bitwise OR over i of (sel[i] ? word_i : 0).
  - sel=0 gives 0.
  - Multiple sel bits give the OR of the selected words; no error, no priority.
- Both mux paths are purely combinational, zero latency.
- gnt_data_out = mux(gnt_data_in, gnt); mux_out = mux(mux_in, mux_sel).
- State register last_gnt (N_PORTS bits):
  - Async reset to 0.
  - Otherwise updated to gnt on every rising clk edge.
- canchange=0: gnt = prio(req), combinational, independent of last_gnt. last_gnt still tracks gnt.
- canchange=1:
  - If (last_gnt & req) != 0, gnt = last_gnt; the previous winner keeps the grant even if a higher-priority port now requests.
  - Else gnt = prio(req).
- gnt is always one-hot or zero; never more than one bit set.
- Reset mid-operation: last_gnt clears immediately (async). gnt then equals prio(req) until the next edge.
- Reset values:
  - No output is registered.
  - While rst_n=0: gnt = prio(req), gnt_data_out follows gnt, mux_out follows mux_sel.
- N_PORTS=1: gnt = req; outputs pass through.
- No X propagation from unselected words. An unselected word containing X must not affect the output.

Test Plan:
- Priority, canchange=0, N=4: req=4'b1010 -> gnt=4'b0010; req=4'b1000 -> gnt=4'b1000; req=0 -> gnt=0.
- Grant mux, N=2, W=32: gnt_data_in={32'hBBBB0001, 32'hAAAA0000}.
  - req=2'b11 -> gnt_data_out=32'hAAAA0000.
  - req=2'b10 -> gnt_data_out=32'hBBBB0001.
  - req=0 -> gnt_data_out=0.
- Standalone mux, N=3: mux_in words 0x11, 0x22, 0x44 (W=8).
  - mux_sel=3'b100 -> 0x44.
  - mux_sel=3'b011 -> 0x33 (OR).
  - mux_sel=0 -> 0x00.
- Sticky grant, canchange=1, N=2:
  - req=2'b10 for one cycle: gnt=2'b10 and is registered.
  - Then req=2'b11 -> gnt stays 2'b10.
  - Then req=2'b01 -> gnt=2'b01.
- Async reset: with canchange=1 and last_gnt=2'b10, pulse rst_n low between edges with req=2'b11 -> gnt switches to 2'b01 immediately.
- Randomised: 1000 cycles of random req/canchange, N=5. Check gnt is one-hot or zero, is a subset of req, and matches the reference priority/sticky rule each cycle.

Source files
------------

// File: rtl/onehot_prio_select.sv
`default_nettype none
// ============================================================================
// Module   : onehot_prio_select
// Brief    : Strict-priority / sticky one-hot arbiter fused with one-hot
//            AND-OR data multiplexers (granted path and standalone path).
// Revision : 1.0 - initial release
// ============================================================================

// One-hot AND-OR multiplexer. Unselected words are masked before the OR,
// so an unknown value in a word whose select is low cannot reach the output.
module onehot_prio_select_mux #(
  parameter int N_PORTS = 2,
  parameter int W_DATA  = 32
) (
  input  logic [N_PORTS-1:0]        sel,
  input  logic [N_PORTS*W_DATA-1:0] data_in,
  output logic [W_DATA-1:0]         data_out
);

  logic [W_DATA-1:0] w_term [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_term
      assign w_term[gi] = data_in[gi*W_DATA +: W_DATA] & {W_DATA{sel[gi]}};
    end
  endgenerate

  always_comb begin
    data_out = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      data_out = data_out | w_term[i];
    end
  end

endmodule

module onehot_prio_select #(
  parameter int N_PORTS = 2,
  parameter int W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      canchange,
  input  logic [N_PORTS-1:0]        req,
  output logic [N_PORTS-1:0]        gnt,
  input  logic [N_PORTS*W_DATA-1:0] gnt_data_in,
  output logic [W_DATA-1:0]         gnt_data_out,
  input  logic [N_PORTS-1:0]        mux_sel,
  input  logic [N_PORTS*W_DATA-1:0] mux_in,
  output logic [W_DATA-1:0]         mux_out
);

  logic [N_PORTS-1:0] r_last_gnt;
  logic [N_PORTS-1:0] w_prio;
  logic               w_hold;

  // Two's-complement trick isolates the lowest set request bit.
  assign w_prio = req & (~req + N_PORTS'(1));

  // r_last_gnt is always one-hot or zero, so holding it keeps gnt one-hot.
  assign w_hold = canchange && (|(r_last_gnt & req));

  always_comb begin
    gnt = w_prio;
    if (w_hold) begin
      gnt = r_last_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= '0;
    end else begin
      r_last_gnt <= gnt;
    end
  end

  onehot_prio_select_mux #(
    .N_PORTS (N_PORTS),
    .W_DATA  (W_DATA)
  ) u_gnt_mux (
    .sel      (gnt),
    .data_in  (gnt_data_in),
    .data_out (gnt_data_out)
  );

  onehot_prio_select_mux #(
    .N_PORTS (N_PORTS),
    .W_DATA  (W_DATA)
  ) u_std_mux (
    .sel      (mux_sel),
    .data_in  (mux_in),
    .data_out (mux_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_onehot_prio_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_prio_select
// Brief    : Directed-vector bench for onehot_prio_select over several sizes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_prio_select;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // N=4, W=8
  logic       cc4;
  logic [3:0] req4, gnt4, msel4;
  logic [31:0] gdi4, mi4;
  logic [7:0] gdo4, mo4;
  // N=2, W=32
  logic       cc2;
  logic [1:0] req2, gnt2, msel2;
  logic [63:0] gdi2, mi2;
  logic [31:0] gdo2, mo2;
  // N=3, W=8
  logic       cc3;
  logic [2:0] req3, gnt3, msel3;
  logic [23:0] gdi3, mi3;
  logic [7:0] gdo3, mo3;
  // N=5, W=8
  logic       cc5;
  logic [4:0] req5, gnt5, msel5;
  logic [39:0] gdi5, mi5;
  logic [7:0] gdo5, mo5;
  // N=1, W=8
  logic       cc1;
  logic [0:0] req1, gnt1, msel1;
  logic [7:0] gdi1, mi1, gdo1, mo1;

  onehot_prio_select #(.N_PORTS(4), .W_DATA(8)) u_n4 (
    .clk(clk), .rst_n(rst_n), .canchange(cc4), .req(req4), .gnt(gnt4),
    .gnt_data_in(gdi4), .gnt_data_out(gdo4), .mux_sel(msel4), .mux_in(mi4), .mux_out(mo4));
  onehot_prio_select #(.N_PORTS(2), .W_DATA(32)) u_n2 (
    .clk(clk), .rst_n(rst_n), .canchange(cc2), .req(req2), .gnt(gnt2),
    .gnt_data_in(gdi2), .gnt_data_out(gdo2), .mux_sel(msel2), .mux_in(mi2), .mux_out(mo2));
  onehot_prio_select #(.N_PORTS(3), .W_DATA(8)) u_n3 (
    .clk(clk), .rst_n(rst_n), .canchange(cc3), .req(req3), .gnt(gnt3),
    .gnt_data_in(gdi3), .gnt_data_out(gdo3), .mux_sel(msel3), .mux_in(mi3), .mux_out(mo3));
  onehot_prio_select #(.N_PORTS(5), .W_DATA(8)) u_n5 (
    .clk(clk), .rst_n(rst_n), .canchange(cc5), .req(req5), .gnt(gnt5),
    .gnt_data_in(gdi5), .gnt_data_out(gdo5), .mux_sel(msel5), .mux_in(mi5), .mux_out(mo5));
  onehot_prio_select #(.N_PORTS(1), .W_DATA(8)) u_n1 (
    .clk(clk), .rst_n(rst_n), .canchange(cc1), .req(req1), .gnt(gnt1),
    .gnt_data_in(gdi1), .gnt_data_out(gdo1), .mux_sel(msel1), .mux_in(mi1), .mux_out(mo1));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference lowest-index-wins priority for the 5-port instance.
  function automatic logic [4:0] ref_prio5(input logic [4:0] r);
    ref_prio5 = '0;
    for (int i = 4; i >= 0; i--) begin
      if (r[i]) ref_prio5 = 5'(1) << i;
    end
  endfunction

  logic [4:0] m_last5;
  logic [4:0] exp5;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cc4 = 0; req4 = 0; msel4 = 0; gdi4 = 32'h44332211; mi4 = 0;
    cc2 = 1; req2 = 2'b11; msel2 = 0; gdi2 = {32'hBBBB0001, 32'hAAAA0000}; mi2 = 0;
    cc3 = 0; req3 = 0; msel3 = 3'b010; gdi3 = 0; mi3 = {8'h44, 8'h22, 8'h11};
    cc5 = 0; req5 = 0; msel5 = 0; gdi5 = 0; mi5 = 0;
    cc1 = 0; req1 = 1'b1; msel1 = 1'b1; gdi1 = 8'h5A; mi1 = 8'hC3;

    // Reset state: outputs are combinational even while held in reset.
    #12;
    check_eq("rst_gnt2", 64'(gnt2), 64'h1);
    check_eq("rst_gdo2", 64'(gdo2), 64'hAAAA0000);
    check_eq("rst_mo3", 64'(mo3), 64'h22);
    @(negedge clk);
    rst_n = 1'b1;

    // Priority, N=4
    req4 = 4'b1010; #1; check_eq("prio4_1010", 64'(gnt4), 64'h2);
    check_eq("prio4_data", 64'(gdo4), 64'h22);
    req4 = 4'b1000; #1; check_eq("prio4_1000", 64'(gnt4), 64'h8);
    check_eq("prio4_data8", 64'(gdo4), 64'h44);
    req4 = 4'b0000; #1; check_eq("prio4_0", 64'(gnt4), 64'h0);
    check_eq("prio4_data0", 64'(gdo4), 64'h0);

    // Grant mux, N=2, non-sticky
    @(negedge clk); cc2 = 0;
    req2 = 2'b11; #1; check_eq("gmux_11", 64'(gdo2), 64'hAAAA0000);
    req2 = 2'b10; #1; check_eq("gmux_10", 64'(gdo2), 64'hBBBB0001);
    req2 = 2'b00; #1; check_eq("gmux_00", 64'(gdo2), 64'h0);
    // Unselected unknown word must not leak through.
    gdi2 = {32'hxxxxxxxx, 32'hAAAA0000}; req2 = 2'b01; #1;
    check_eq("gmux_xmask", 64'(gdo2), 64'hAAAA0000);
    gdi2 = {32'hBBBB0001, 32'hAAAA0000};

    // Standalone mux, N=3
    msel3 = 3'b100; #1; check_eq("smux_100", 64'(mo3), 64'h44);
    msel3 = 3'b011; #1; check_eq("smux_011", 64'(mo3), 64'h33);
    msel3 = 3'b000; #1; check_eq("smux_000", 64'(mo3), 64'h00);
    mi3 = {8'h44, 8'hxx, 8'h11}; msel3 = 3'b101; #1;
    check_eq("smux_xmask", 64'(mo3), 64'h55);

    // N=1 passthrough
    check_eq("n1_gnt", 64'(gnt1), 64'h1);
    check_eq("n1_gdo", 64'(gdo1), 64'h5A);
    check_eq("n1_mo", 64'(mo1), 64'hC3);
    req1 = 1'b0; msel1 = 1'b0; #1;
    check_eq("n1_gnt0", 64'(gnt1), 64'h0);
    check_eq("n1_mo0", 64'(mo1), 64'h0);

    // Sticky grant, N=2
    @(negedge clk); cc2 = 1; req2 = 2'b10; #1;
    check_eq("stky_first", 64'(gnt2), 64'h2);
    @(negedge clk); req2 = 2'b11; #1;
    check_eq("stky_hold", 64'(gnt2), 64'h2);
    check_eq("stky_hold_d", 64'(gdo2), 64'hBBBB0001);
    @(negedge clk); req2 = 2'b01; #1;
    check_eq("stky_release", 64'(gnt2), 64'h1);
    @(negedge clk); req2 = 2'b11; #1;
    check_eq("stky_hold0", 64'(gnt2), 64'h1);
    // Same vectors with canchange low fall back to pure priority.
    @(negedge clk); req2 = 2'b10;
    @(negedge clk); cc2 = 0; req2 = 2'b11; #1;
    check_eq("nostky_11", 64'(gnt2), 64'h1);

    // Async reset between edges clears the held winner immediately.
    @(negedge clk); cc2 = 1; req2 = 2'b10;
    @(negedge clk); req2 = 2'b11; #1;
    check_eq("arst_pre", 64'(gnt2), 64'h2);
    #1 rst_n = 1'b0; #1;
    check_eq("arst_low", 64'(gnt2), 64'h1);
    rst_n = 1'b1; #1;
    check_eq("arst_rel", 64'(gnt2), 64'h1);

    // Randomised sticky/priority on N=5 against a reference model.
    @(negedge clk);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    m_last5 = '0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      req5 = 5'($urandom_range(0, 31));
      cc5  = 1'($urandom_range(0, 1));
      #1;
      if (cc5 && ((m_last5 & req5) != 0)) exp5 = m_last5;
      else exp5 = ref_prio5(req5);
      check_eq("rnd_gnt", 64'(gnt5), 64'(exp5));
      check_eq("rnd_onehot0", 64'($onehot0(gnt5)), 64'h1);
      check_eq("rnd_subset", 64'(gnt5 & ~req5), 64'h0);
      @(posedge clk);
      m_last5 = exp5;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
